// File: rtl/seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : seq_pkg                                                      |
// | Purpose   : Shared definitions for the serial sequence path: frame FSM   |
// |             state encoding, default payload/preamble sizes and a small   |
// |             sizing helper. Reused by the transmitter, the matching       |
// |             detector and the bench.                                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package seq_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_PRE_LEN = 4;

    // Explicit encoding so every consumer of the package agrees on values.
    // PAR is always encoded; it is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SEP  = 3'd2,
        DATA = 3'd3,
        PAR  = 3'd4
    } seq_state_e;

    function automatic int seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : seq_tx_if                                                    |
// | Purpose   : Parallel word handshake plus serial line outputs of seq_tx.  |
// | Signals   : in_valid, in_data[DATA_W]  source -> transmitter             |
// |             in_ready, out, out_en,     transmitter -> source / line      |
// |             busy, done                                                   |
// | Modports  : master (data source side), slave (transmitter side)          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface seq_tx_if #(
    parameter int DATA_W = seq_pkg::DEFAULT_DATA_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              out_en;
    logic              busy;
    logic              done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out,
        input  out_en,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out,
        output out_en,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/seq_piso.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : seq_piso                                                     |
// | Purpose   : Loadable parallel-in / serial-out shift register, MSB first. |
// | Ports     : clk, rst         clock, synchronous active-high reset        |
// |             load, load_data  capture a new word (load beats shift)       |
// |             shift            move contents one place toward the MSB      |
// |             msb_next         MSB the register will hold after this edge  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module seq_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb_next
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            // A shift works for DATA_W == 1 too (register simply clears).
            sr_d = sr_q << 1;
        end
    end

    // Exposing the next MSB lets the owner register the serial bit so the
    // line output comes straight from a flop.
    assign msb_next = sr_d[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : seq_tx                                                       |
// | Purpose   : Serial frame transmitter. Accepts a word over valid/ready    |
// |             and sends PRE_LEN ones, one zero, then the payload MSB       |
// |             first, one bit per clock.                                    |
// | Ports     : clk, rst   clock, synchronous active-high reset              |
// |             bus        seq_tx_if.slave (in_valid/in_data/in_ready,       |
// |                        out, out_en, busy, done)                          |
// | Options   : SEQ_TX_PARITY_EN  append an even-parity bit after payload    |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module seq_tx
    import seq_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int PRE_LEN = DEFAULT_PRE_LEN
) (
    input  logic    clk,
    input  logic    rst,
    seq_tx_if.slave bus
);

    localparam int CNT_W = $clog2(seq_max(PRE_LEN, DATA_W) + 1);
    localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_en_q, out_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in_ready_q, in_ready_d;
    logic             load;
    logic             shift;
    logic             msb_next;
`ifdef SEQ_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    seq_piso #(
        .DATA_W    (DATA_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (bus.in_data),
        .msb_next  (msb_next)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;

        case (state_q)
            // in_ready is 1 exactly in IDLE, so in_valid alone completes
            // the handshake here.
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (cnt_q == C_PRE_LAST) begin
                    state_d = SEP;
                end
            end
            SEP: begin
                state_d = DATA;
            end
            DATA: begin
                shift = 1'b1;
                if (cnt_q == C_DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // One counter serves PRE and DATA; it restarts on every transition.
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

`ifdef SEQ_TX_PARITY_EN
        parity_d = load ? ^bus.in_data : parity_q;
`endif

        // Outputs are decoded from the next state so they land in flops and
        // line up with the state they describe.
        out_d = 1'b0;
        case (state_d)
            PRE:     out_d = 1'b1;
            DATA:    out_d = msb_next;
`ifdef SEQ_TX_PARITY_EN
            PAR:     out_d = parity_d;
`endif
            default: out_d = 1'b0;
        endcase

        out_en_d   = (state_d != IDLE);
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE);
`ifdef SEQ_TX_PARITY_EN
        done_d     = (state_d == PAR);
`else
        done_d     = (state_d == DATA) && (cnt_d == C_DATA_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            out_en_q   <= out_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
`ifdef SEQ_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.out      = out_q;
    assign bus.out_en   = out_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.in_ready = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_seq_tx                                                    |
// | Purpose   : Self-checking bench for seq_tx. Expected frame bits are      |
// |             queued when a word is handed over and compared as the line   |
// |             emits them. Honours SEQ_TX_PARITY_EN.                        |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_tx;
    import seq_pkg::*;

    localparam int DW = DEFAULT_DATA_W;
    localparam int PL = DEFAULT_PRE_LEN;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int F = PL + 1 + DW + PAR_EN;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    seq_tx_if #(.DATA_W(DW)) bus ();

    seq_tx #(
        .DATA_W  (DW),
        .PRE_LEN (PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input logic par);
        exp_t e;
        for (int i = 0; i < PL; i++) begin
            e.b = 1'b1; e.done = 1'b0; sb.push_back(e);
        end
        e.b = 1'b0; e.done = 1'b0; sb.push_back(e);
        for (int i = 0; i < DW; i++) begin
            e.b    = d[DW-1-i];
            e.done = (PAR_EN == 0) && (i == DW - 1);
            sb.push_back(e);
        end
        if (PAR_EN != 0) begin
            e.b = par; e.done = 1'b1; sb.push_back(e);
        end
    endtask

    // Line monitor: every cycle either a queued frame bit or a quiet idle line.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_bit", 32'(bus.out_en), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out",      32'(bus.out),      32'(e.b));
                    check("done",     32'(bus.done),     32'(e.done));
                    check("busy",     32'(bus.busy),     32'd1);
                    check("in_ready", 32'(bus.in_ready), 32'd0);
                end
            end else begin
                check("idle_out",      32'(bus.out),      32'd0);
                check("idle_done",     32'(bus.done),     32'd0);
                check("idle_busy",     32'(bus.busy),     32'd0);
                check("idle_in_ready", 32'(bus.in_ready), 32'd1);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the first frame bit.
    task automatic send(input logic [DW-1:0] d, input logic par);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        check("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        push_frame(d, par);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("start_latency", 32'(bus.out_en), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // payload, expected even parity (count of ones mod 2)
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h3C, 1'b0};
        vecs[3] = '{8'h81, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'hE0, 1'b1};
        vecs[6] = '{8'h5A, 1'b0};
        vecs[7] = '{8'hFE, 1'b1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out",      32'(bus.out),      32'd0);
        check("rst_out_en",   32'(bus.out_en),   32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        // Table-driven single frames
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, vecs[i].par);
            drain();
        end

        // in_valid held high: FF then 00, exactly one idle cycle between
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        push_frame(8'hFF, 1'b0);
        @(negedge clk);
        bus.in_data = 8'h00;
        cyc = 1;
        while (bus.in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        check("b2b_period", 32'(cyc), 32'(F + 1));
        push_frame(8'h00, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_start", 32'(bus.out_en), 32'd1);
        drain();

        // Reset on the third payload bit; in_valid high during reset
        send(8'hC3, 1'b0);
        repeat (PL + 1 + 2) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        check("abort_out_en",   32'(bus.out_en),   32'd0);
        check("abort_out",      32'(bus.out),      32'd0);
        check("abort_done",     32'(bus.done),     32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_wins", 32'(bus.out_en), 32'd0);
        send(8'h3C, 1'b0);
        drain();

        // Input noise while busy must not disturb the captured word
        send(8'h96, 1'b0);
        for (int i = 0; i < F - 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = DW'($urandom);
        end
        bus.in_valid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("final_queue", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
